// File: rtl/demux_buf.sv
// Registered 1:2 demultiplexer steering 5-bit words into two independent 2-entry FIFOs.
// Optional per-channel accepted-word counters (Cnt1/Cnt2) are built when DEMUX_STAT_EN is defined.
module demux_buf #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Din,
  input  logic              Din_valid,
  input  logic              Sel,
  output logic              Din_ready,
  output logic [DATA_W-1:0] Dout1,
  output logic              Dout1_valid,
  input  logic              Dout1_ready,
  output logic [DATA_W-1:0] Dout2,
  output logic              Dout2_valid,
  input  logic              Dout2_ready
`ifdef DEMUX_STAT_EN
  ,
  output logic [7:0]        Cnt1,
  output logic [7:0]        Cnt2
`endif
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Index 0 is channel 1 (Sel=1), index 1 is channel 2 (Sel=0).
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [1:0]        occ [2];
  logic              rptr [2];
  logic              wptr [2];
  logic              full [2];
  logic              push [2];
  logic              pop  [2];

  // No pass-through: ready looks only at registered occupancy, never at a same-cycle pop.
  always_comb begin
    full[0]   = (occ[0] == FULL);
    full[1]   = (occ[1] == FULL);
    Din_ready = Sel ? !full[0] : !full[1];
    push[0]   = Din_valid && Sel && !full[0];
    push[1]   = Din_valid && !Sel && !full[1];
    pop[0]    = (occ[0] != 2'd0) && Dout1_ready;
    pop[1]    = (occ[1] != 2'd0) && Dout2_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        occ[c]  <= 2'd0;
        rptr[c] <= 1'b0;
        wptr[c] <= 1'b0;
        for (int e = 0; e < DEPTH; e++) mem[c][e] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wptr[c]] <= Din;
          wptr[c]         <= ~wptr[c];
        end
        if (pop[c]) rptr[c] <= ~rptr[c];
        case ({push[c], pop[c]})
          2'b10:   occ[c] <= occ[c] + 2'd1;
          2'b01:   occ[c] <= occ[c] - 2'd1;
          default: occ[c] <= occ[c];
        endcase
      end
    end
  end

  assign Dout1       = mem[0][rptr[0]];
  assign Dout2       = mem[1][rptr[1]];
  assign Dout1_valid = (occ[0] != 2'd0);
  assign Dout2_valid = (occ[1] != 2'd0);

`ifdef DEMUX_STAT_EN
  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Cnt1 <= 8'd0;
      Cnt2 <= 8'd0;
    end else begin
      if (push[0]) Cnt1 <= Cnt1 + 8'd1;
      if (push[1]) Cnt2 <= Cnt2 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Directed plus randomized bench for demux_buf against a queue-based channel model.
// Build with DEMUX_STAT_EN defined to also cover the accepted-word counters.
module tb_demux_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] Din = '0;
  logic       Din_valid = 1'b0;
  logic       Sel = 1'b0;
  logic       Din_ready;
  logic [4:0] Dout1, Dout2;
  logic       Dout1_valid, Dout2_valid;
  logic       Dout1_ready = 1'b0;
  logic       Dout2_ready = 1'b0;
`ifdef DEMUX_STAT_EN
  logic [7:0] Cnt1, Cnt2;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0] q1 [$];
  logic [4:0] q2 [$];
  int         cnt1 = 0;
  int         cnt2 = 0;

  demux_buf dut (
    .clk         (clk),
    .rst         (rst),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Sel         (Sel),
    .Din_ready   (Din_ready),
    .Dout1       (Dout1),
    .Dout1_valid (Dout1_valid),
    .Dout1_ready (Dout1_ready),
    .Dout2       (Dout2),
    .Dout2_valid (Dout2_valid),
    .Dout2_ready (Dout2_ready)
`ifdef DEMUX_STAT_EN
    ,
    .Cnt1        (Cnt1),
    .Cnt2        (Cnt2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef DEMUX_STAT_EN
    chk("cnt1", 32'(Cnt1), 32'(cnt1 % 256));
    chk("cnt2", 32'(Cnt2), 32'(cnt2 % 256));
`endif
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_v1"}, 32'(Dout1_valid), 32'd0);
    chk({tag, "_v2"}, 32'(Dout2_valid), 32'd0);
    chk({tag, "_d1"}, 32'(Dout1), 32'd0);
    chk({tag, "_d2"}, 32'(Dout2), 32'd0);
    chk({tag, "_rdy"}, 32'(Din_ready), 32'd1);
    chk_stats();
  endtask

  // Reset is raised between clock edges; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    Din_valid = 1'b0;
    #1;
    chk_empty({tag, "_async"});
    @(posedge clk);
    #1;
    chk_empty({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q2.delete();
    cnt1 = 0;
    cnt2 = 0;
    #1;
    chk_empty({tag, "_rel"});
  endtask

  // One clock cycle: drive, check against the model, then advance the model on the edge.
  task automatic cyc(input logic [4:0] d, input logic v, input logic s,
                     input logic r1, input logic r2);
    logic exp_rdy, acc, p1, p2;
    Din = d; Din_valid = v; Sel = s; Dout1_ready = r1; Dout2_ready = r2;
    #1;
    exp_rdy = s ? (q1.size() != 2) : (q2.size() != 2);
    chk("din_ready", 32'(Din_ready), 32'(exp_rdy));
    chk("dout1_valid", 32'(Dout1_valid), 32'(q1.size() != 0));
    chk("dout2_valid", 32'(Dout2_valid), 32'(q2.size() != 0));
    if (q1.size() != 0) chk("dout1", 32'(Dout1), 32'(q1[0]));
    if (q2.size() != 0) chk("dout2", 32'(Dout2), 32'(q2[0]));
    chk_stats();
    acc = v && exp_rdy;
    p1  = r1 && (q1.size() != 0);
    p2  = r2 && (q2.size() != 0);
    @(posedge clk);
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (acc) begin
      if (s) begin q1.push_back(d); cnt1++; end
      else   begin q2.push_back(d); cnt2++; end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset("rst0");
    cyc(5'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Routing with both consumers ready
    cyc(5'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(5'h1C, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Backpressure on channel 1: third push refused, ready returns after first pop
    cyc(5'h01, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(5'h02, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(5'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(5'h04, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b1, 1'b1, 1'b1);

    // Channel 1 full and stalled while channel 2 keeps working
    cyc(5'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(5'h0B, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(5'h15, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Channel 2 at occupancy 1 with push and pop together
    cyc(5'h06, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(5'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(5'h08, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Both channels full, then reset mid-stream
    cyc(5'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(5'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(5'h13, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(5'h14, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    do_reset("rst_mid");
    cyc(5'h09, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // 257 pushes into channel 1 exercise counter wrap
    for (int i = 0; i < 257; i++) cyc(5'(i), 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(5'h00, 1'b0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic with independent stalls
    for (int i = 0; i < 400; i++)
      cyc(5'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
          1'($urandom), ($urandom_range(0, 2) == 0));
    for (int i = 0; i < 4; i++) cyc(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_buf.md
# demux_buf

Registered 1:2 demultiplexer for 5-bit words; the inverse of the counter-path 2:1 selector. Each word presented on `Din` is steered by `Sel` into one of two independent 2-entry output buffers (`Sel`=1 to channel 1, `Sel`=0 to channel 2), each with its own valid/ready handshake. It distributes synchronous-counter values to two downstream consumers that may stall independently.

## Interface
- `DEPTH`, 2: entries per channel buffer. Fixed at 2; no other value is supported.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `Din`  input  [4:0]  data word.
- `Din_valid`  input  1  `Din`/`Sel` hold a word to transfer.
- `Sel`  input  1  destination: 1 selects channel 1, 0 selects channel 2.
- `Din_ready`  output  1  the selected channel can accept a word.
- `Dout1`, `Dout2`  output  [4:0]  head entry of channel 1 / channel 2.
- `Dout1_valid`, `Dout2_valid`  output  1  channel holds at least one entry.
- `Dout1_ready`, `Dout2_ready`  input  1  consumer takes the head entry.
- `Cnt1`, `Cnt2`  output  [7:0]  accepted-word counters. Present only with `DEMUX_STAT_EN`.

## Operation
- Each channel is a 2-entry FIFO with a 2-bit occupancy (0..2), a 1-bit read pointer, and a 1-bit write pointer.
- `Din_ready` is combinational:
  - `Sel`=1: `Din_ready` = (occ1 != 2).
  - `Sel`=0: `Din_ready` = (occ2 != 2).
- Push: `Din_valid && Din_ready` writes `Din` into the selected channel at its write pointer, then increments that pointer (mod 2) and that occupancy.
- Pop: `DoutN_valid && DoutN_ready` increments the channel's read pointer (mod 2) and decrements its occupancy.
- `DoutN` = entry at the read pointer. `DoutN_valid` = (occN != 0).
- When `DoutN_valid` is 0, `DoutN` holds the last value written to that entry, or 0 after reset. Consumers must ignore `DoutN` while `DoutN_valid` is 0.
- A push and a pop on the same channel in the same cycle leave occupancy unchanged and advance both pointers.
- No pass-through: when occ=2, a push is refused even if a pop occurs that cycle. `Din_ready` depends only on registered state and `Sel`.
- Words on the same channel are delivered in acceptance order. The two channels never interact; a stalled channel never blocks pushes to the other.
- `Sel`, `Din`, and `Din_ready` may change every cycle. A transfer happens only in a cycle where `Din_valid` and `Din_ready` are both 1.
- `DoutN_ready` asserted while `DoutN_valid` is 0 has no effect.

## Timing
- Reset values, asserted asynchronously and held while `rst` is high:
  - occupancies 0, all pointers 0, storage 0.
  - `Dout1_valid` = `Dout2_valid` = 0; `Dout1` = `Dout2` = 0.
  - `Din_ready` = 1.
  - `Cnt1` = `Cnt2` = 0.
- Reset mid-transfer discards all buffered words. The first push after `rst` falls is accepted on the first rising edge with `rst` low.
- Latency: a word accepted at edge k appears on `DoutN` with `DoutN_valid`=1 after edge k, i.e. usable in cycle k+1.
- Throughput: one push per cycle into a non-full channel. Sustained 1 word/cycle per channel when its consumer holds ready high.
- Occupancy boundaries:
  - occ 2 to 1 on a pop re-enables `Din_ready` for that channel in the next cycle.
  - occ 0 to 1 on a push raises valid in the next cycle.

## Configuration
- `DEMUX_STAT_EN` defined:
  - `Cnt1`/`Cnt2` ports and registers exist.
  - Each increments by 1 on every push accepted into its channel.
  - 8-bit, wraps 255 to 0, reset to 0.
- `DEMUX_STAT_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset then idle: `rst` pulse, no stimulus -> both valids 0, both `Dout` 0, `Din_ready`=1, `Cnt1`=`Cnt2`=0.
- Routing: push 5'h03 with `Sel`=1, then 5'h1C with `Sel`=0, both readies high -> `Dout1`=03 valid for exactly one cycle, `Dout2`=1C valid for exactly one cycle, 1-cycle latency each.
- Full/backpressure: `Dout1_ready`=0, push 01, 02, 03 with `Sel`=1 -> third word refused (`Din_ready`=0). Then raise ready -> 01, 02 delivered in order, and `Din_ready` returns to 1 one cycle after the first pop.
- Independence and simultaneous push/pop:
  - channel 1 full and stalled, push 5'h15 with `Sel`=0 -> accepted, `Dout2`=15.
  - channel 2 at occ 1 with push and pop in the same cycle -> occ stays 1, order preserved.
- Async reset mid-stream: both channels at occ 2, assert `rst` between clock edges -> valids drop immediately without a clock edge, and buffers read empty afterwards.
- `DEMUX_STAT_EN`: 257 pushes to channel 1 -> `Cnt1`=1, `Cnt2`=0.
